// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : Registered execute-to-memory boundary behind the 16-bit ALU.
//            Captures {result, rd, wen} into a 2-entry FIFO and presents the
//            head entry downstream via valid/ready. Resolves conditional
//            branches from the ALU flags (one-cycle br_taken pulse) and traps
//            on signed overflow for checked add/sub, recording the PC in epc.
// Ports    : clk, rst_n (sync, active low)
//            upstream   : in_valid/in_ready, alu_r, alu_zero, alu_ovfl, in_pc,
//                         in_rd, in_wen, in_br, in_br_target, in_chk_ovfl
//            downstream : out_valid/out_ready, out_r, out_rd, out_wen
//            control    : br_taken, br_target, trap, epc, trap_ack
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
    parameter int WIDTH = 16,
    parameter int RAW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,
    input  logic             alu_ovfl,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [RAW-1:0]   in_rd,
    input  logic             in_wen,
    input  logic [1:0]       in_br,
    input  logic [WIDTH-1:0] in_br_target,
    input  logic             in_chk_ovfl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic [RAW-1:0]   out_rd,
    output logic             out_wen,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_target,
    output logic             trap,
    output logic [WIDTH-1:0] epc,
    input  logic             trap_ack
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t           r_state;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] r_mem_r   [2];
    logic [RAW-1:0]   r_mem_rd  [2];
    logic [1:0]       r_mem_wen;
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;

    // Last popped entry, shown at the outputs while the FIFO is empty
    logic [WIDTH-1:0] r_last_r;
    logic [RAW-1:0]   r_last_rd;
    logic             r_last_wen;

    logic             w_accept;
    logic             w_trap_hit;
    logic             w_push;
    logic             w_pop;
    logic             w_br_cond;

    // in_ready depends only on registered state, never on out_ready
    assign in_ready   = (r_state == RUN) && (r_count != 2'd2);
    assign w_accept   = in_valid && in_ready;
    assign w_trap_hit = w_accept && in_chk_ovfl && alu_ovfl;
    assign w_push     = w_accept && !w_trap_hit;
    assign out_valid  = (r_count != 2'd0);
    assign w_pop      = out_valid && out_ready;
    assign trap       = (r_state == TRAP);

    always_comb begin
        w_br_cond = 1'b0;
        case (in_br)
            2'b01:   w_br_cond = alu_zero;
            2'b10:   w_br_cond = !alu_zero;
            2'b11:   w_br_cond = alu_r[0];
            default: w_br_cond = 1'b0;
        endcase
    end

    assign out_r   = out_valid ? r_mem_r[r_head]   : r_last_r;
    assign out_rd  = out_valid ? r_mem_rd[r_head]  : r_last_rd;
    assign out_wen = out_valid ? r_mem_wen[r_head] : r_last_wen;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RUN;
            for (int i = 0; i < 2; i++) begin
                r_mem_r[i]  <= '0;
                r_mem_rd[i] <= '0;
            end
            r_mem_wen  <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_count    <= 2'd0;
            r_last_r   <= '0;
            r_last_rd  <= '0;
            r_last_wen <= 1'b0;
            br_taken   <= 1'b0;
            br_target  <= '0;
            epc        <= '0;
        end else begin
            if (w_push) begin
                r_mem_r[r_tail]   <= alu_r;
                r_mem_rd[r_tail]  <= in_rd;
                r_mem_wen[r_tail] <= in_wen;
                r_tail            <= ~r_tail;
            end

            if (w_pop) begin
                r_last_r   <= r_mem_r[r_head];
                r_last_rd  <= r_mem_rd[r_head];
                r_last_wen <= r_mem_wen[r_head];
                r_head     <= ~r_head;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            // A trapping accept never pushes, so it can never raise br_taken
            br_taken <= w_push && w_br_cond;
            if (w_push && w_br_cond) begin
                br_target <= in_br_target;
            end

            case (r_state)
                RUN: begin
                    if (w_trap_hit) begin
                        r_state <= TRAP;
                        epc     <= in_pc;
                    end
                end
                TRAP: begin
                    if (trap_ack) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Self-checking bench for ex_mem_stage: directed scenarios plus a
//            randomized run checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

    localparam int WIDTH = 16;
    localparam int RAW   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_r;
    logic             alu_zero;
    logic             alu_ovfl;
    logic [WIDTH-1:0] in_pc;
    logic [RAW-1:0]   in_rd;
    logic             in_wen;
    logic [1:0]       in_br;
    logic [WIDTH-1:0] in_br_target;
    logic             in_chk_ovfl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic [RAW-1:0]   out_rd;
    logic             out_wen;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             trap;
    logic [WIDTH-1:0] epc;
    logic             trap_ack;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.WIDTH(WIDTH), .RAW(RAW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_r(alu_r), .alu_zero(alu_zero), .alu_ovfl(alu_ovfl),
        .in_pc(in_pc), .in_rd(in_rd), .in_wen(in_wen),
        .in_br(in_br), .in_br_target(in_br_target), .in_chk_ovfl(in_chk_ovfl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_rd(out_rd), .out_wen(out_wen),
        .br_taken(br_taken), .br_target(br_target),
        .trap(trap), .epc(epc), .trap_ack(trap_ack)
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of pending results plus a few flags
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic [RAW-1:0]   rd;
        logic             wen;
    } ent_t;

    ent_t             m_q[$];
    ent_t             m_last;
    logic             m_trap;
    logic [WIDTH-1:0] m_epc;
    logic             m_br;
    logic [WIDTH-1:0] m_brt;

    function automatic logic branch_wanted(logic [1:0] kind, logic zero, logic [WIDTH-1:0] r);
        if (kind == 2'b01) return zero;
        if (kind == 2'b10) return !zero;
        if (kind == 2'b11) return r[0];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_last = '0;
        m_trap = 1'b0;
        m_epc  = '0;
        m_br   = 1'b0;
        m_brt  = '0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        bit   can_take;
        bit   took;
        ent_t e;
        can_take = !m_trap && (m_q.size() < 2);
        took     = in_valid && can_take;
        if (m_trap && trap_ack) m_trap = 1'b0;
        if (m_q.size() > 0 && out_ready) m_last = m_q.pop_front();
        m_br = 1'b0;
        if (took) begin
            if (in_chk_ovfl && alu_ovfl) begin
                m_trap = 1'b1;
                m_epc  = in_pc;
            end else begin
                e.r = alu_r; e.rd = in_rd; e.wen = in_wen;
                m_q.push_back(e);
                if (branch_wanted(in_br, alu_zero, alu_r)) begin
                    m_br  = 1'b1;
                    m_brt = in_br_target;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus (called at negedge), clock it, return at negedge
    task automatic step(input logic v, input logic [WIDTH-1:0] r, input logic z,
                        input logic ov, input logic [WIDTH-1:0] pc,
                        input logic [1:0] br, input logic [WIDTH-1:0] tgt,
                        input logic chk, input logic ordy, input logic ack);
        in_valid = v; alu_r = r; alu_zero = z; alu_ovfl = ov; in_pc = pc;
        in_rd = r[3:0]; in_wen = r[4]; in_br = br; in_br_target = tgt;
        in_chk_ovfl = chk; out_ready = ordy; trap_ack = ack;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, input logic ack);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 1'b0, ordy, ack);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle(1'b0, 1'b0);
        model_reset();
        do_reset();
        n_vec++;
        if ({in_ready, out_valid, out_r, out_rd, out_wen} !== {1'b1, 1'b0, 16'h0, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_fifo: got rdy=%b v=%b r=%h rd=%h wen=%b want 1 0 0000 0 0",
                     in_ready, out_valid, out_r, out_rd, out_wen);
        end
        n_vec++;
        if ({br_taken, br_target, trap, epc} !== {1'b0, 16'h0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_ctrl: got br=%b tgt=%h trap=%b epc=%h want 0 0000 0 0000",
                     br_taken, br_target, trap, epc);
        end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 16'h0005; vals[1] = 16'h0007; vals[2] = 16'h0009;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, vals[i], 1'b0, 1'b0, 16'h10, 2'b00, 16'h0, 1'b0, 1'b1, 1'b0);
            n_vec++;
            if ({out_valid, in_ready, out_r} !== {1'b1, 1'b1, vals[i]}) begin
                n_err++;
                $display("FAIL stream_%0d: got v=%b rdy=%b r=%h want 1 1 %h",
                         i, out_valid, in_ready, out_r, vals[i]);
            end
        end
        idle(1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        step(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({in_ready, out_valid, out_r} !== {1'b0, 1'b1, 16'h1111}) begin
            n_err++;
            $display("FAIL bp_full: got rdy=%b v=%b r=%h want 0 1 1111", in_ready, out_valid, out_r);
        end
        // Offered third value must be refused while full
        step(1'b1, 16'h3333, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({in_ready, out_r} !== {1'b0, 16'h1111}) begin
            n_err++;
            $display("FAIL bp_hold: got rdy=%b r=%h want 0 1111", in_ready, out_r);
        end
        idle(1'b1, 1'b0);
        n_vec++;
        if ({in_ready, out_valid, out_r} !== {1'b1, 1'b1, 16'h2222}) begin
            n_err++;
            $display("FAIL bp_pop1: got rdy=%b v=%b r=%h want 1 1 2222", in_ready, out_valid, out_r);
        end
        idle(1'b1, 1'b0);
        n_vec++;
        if ({out_valid, out_r} !== {1'b0, 16'h2222}) begin
            n_err++;
            $display("FAIL bp_pop2: got v=%b r=%h want 0 2222", out_valid, out_r);
        end
    endtask

    task automatic test_branch();
        step(1'b1, 16'h0000, 1'b1, 1'b0, 16'h20, 2'b01, 16'h0040, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({br_taken, br_target} !== {1'b1, 16'h0040}) begin
            n_err++;
            $display("FAIL br_taken: got br=%b tgt=%h want 1 0040", br_taken, br_target);
        end
        idle(1'b1, 1'b0);
        n_vec++;
        if (br_taken !== 1'b0) begin
            n_err++;
            $display("FAIL br_pulse: got br=%b want 0", br_taken);
        end
        step(1'b1, 16'h00AB, 1'b0, 1'b0, 16'h24, 2'b01, 16'h0080, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({br_taken, out_valid, out_r} !== {1'b0, 1'b1, 16'h00AB}) begin
            n_err++;
            $display("FAIL br_not: got br=%b v=%b r=%h want 0 1 00ab", br_taken, out_valid, out_r);
        end
        idle(1'b1, 1'b0);
    endtask

    task automatic test_trap();
        step(1'b1, 16'h0AAA, 1'b0, 1'b0, 16'h0120, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b1, 16'h0122, 2'b00, 16'h0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if ({trap, epc, in_ready, out_valid, out_r} !== {1'b1, 16'h0122, 1'b0, 1'b1, 16'h0AAA}) begin
            n_err++;
            $display("FAIL trap_entry: got trap=%b epc=%h rdy=%b v=%b r=%h want 1 0122 0 1 0aaa",
                     trap, epc, in_ready, out_valid, out_r);
        end
        // Older entry drains; an offered instruction is not accepted in TRAP
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0124, 2'b00, 16'h0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({trap, out_valid, out_r} !== {1'b1, 1'b0, 16'h0AAA}) begin
            n_err++;
            $display("FAIL trap_drain: got trap=%b v=%b r=%h want 1 0 0aaa", trap, out_valid, out_r);
        end
        idle(1'b1, 1'b1);
        n_vec++;
        if ({trap, in_ready, out_valid, epc} !== {1'b0, 1'b1, 1'b0, 16'h0122}) begin
            n_err++;
            $display("FAIL trap_ack: got trap=%b rdy=%b v=%b epc=%h want 0 1 0 0122",
                     trap, in_ready, out_valid, epc);
        end
        step(1'b1, 16'h7777, 1'b0, 1'b1, 16'h0130, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({trap, out_valid, out_r, epc} !== {1'b0, 1'b1, 16'h7777, 16'h0122}) begin
            n_err++;
            $display("FAIL trap_unchecked: got trap=%b v=%b r=%h epc=%h want 0 1 7777 0122",
                     trap, out_valid, out_r, epc);
        end
        idle(1'b1, 1'b1);
        n_vec++;
        if (trap !== 1'b0) begin
            n_err++;
            $display("FAIL trap_ack_in_run: got trap=%b want 0", trap);
        end
    endtask

    task automatic test_trap_beats_branch();
        step(1'b1, 16'h0000, 1'b1, 1'b1, 16'h0200, 2'b01, 16'h0300, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if ({trap, br_taken, epc, out_valid} !== {1'b1, 1'b0, 16'h0200, 1'b0}) begin
            n_err++;
            $display("FAIL trap_vs_br: got trap=%b br=%b epc=%h v=%b want 1 0 0200 0",
                     trap, br_taken, epc, out_valid);
        end
        idle(1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16'h4444, 1'b0, 1'b0, 16'h0400, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h5555, 1'b0, 1'b1, 16'h0402, 2'b00, 16'h0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if ({trap, out_valid} !== {1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL rstmid_pre: got trap=%b v=%b want 1 1", trap, out_valid);
        end
        do_reset();
        n_vec++;
        if ({out_valid, trap, epc, in_ready, out_r} !== {1'b0, 1'b0, 16'h0, 1'b1, 16'h0}) begin
            n_err++;
            $display("FAIL rstmid_post: got v=%b trap=%b epc=%h rdy=%b r=%h want 0 0 0000 1 0000",
                     out_valid, trap, epc, in_ready, out_r);
        end
    endtask

    task automatic test_random();
        ent_t head;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0, 16'($urandom), 2'($urandom_range(0, 3)),
                     16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 3) == 0);
            end
            head = (m_q.size() > 0) ? m_q[0] : m_last;
            n_vec++;
            if ({out_valid, out_r, out_rd, out_wen} !== {m_q.size() > 0, head.r, head.rd, head.wen}) begin
                n_err++;
                $display("FAIL rnd_out[%0d]: got v=%b r=%h rd=%h wen=%b want %b %h %h %b", i,
                         out_valid, out_r, out_rd, out_wen, m_q.size() > 0, head.r, head.rd, head.wen);
            end
            n_vec++;
            if ({in_ready, br_taken, trap, epc} !== {!m_trap && m_q.size() < 2, m_br, m_trap, m_epc}) begin
                n_err++;
                $display("FAIL rnd_ctrl[%0d]: got rdy=%b br=%b trap=%b epc=%h want %b %b %b %h", i,
                         in_ready, br_taken, trap, epc, !m_trap && m_q.size() < 2, m_br, m_trap, m_epc);
            end
            if (m_br) begin
                n_vec++;
                if (br_target !== m_brt) begin
                    n_err++;
                    $display("FAIL rnd_brt[%0d]: got %h want %h", i, br_target, m_brt);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_r = '0; alu_zero = 1'b0; alu_ovfl = 1'b0;
        in_pc = '0; in_rd = '0; in_wen = 1'b0; in_br = 2'b00; in_br_target = '0;
        in_chk_ovfl = 1'b0; out_ready = 1'b0; trap_ack = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_trap();
        test_trap_beats_branch();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
